reset_tick_gen: RTL and testbench

RESET_TICK_GEN -- requirements
Module: reset_tick_gen

---
 rtl/clk_rst_pkg.sv | 21 ++
 rtl/tick_div.sv | 52 +++++
 rtl/reset_tick_gen.sv | 115 +++++++++++
 tb/tb_reset_tick_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared definitions for the reset sequencer and tick-enable dividers:
// sequencer state encoding, default sizes and a counter-width helper.
`timescale 1ns/1ps
package clk_rst_pkg;

   localparam int DEF_DIV_WIDTH   = 16;
   localparam int DEF_HOLD_CYCLES = 256;
   localparam int DEF_LOCK_FILTER = 16;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_HOLD      = 2'd1,
      ST_RUN       = 2'd2
   } rst_state_t;

   // Bits needed for a counter that runs 0..count-1, never less than one bit.
   function automatic int counter_width(input int count);
      return (count < 2) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/tick_div.sv
// One tick-enable channel: a shadow divisor register and a wrap counter that
// emits a registered one-cycle pulse every max(div,1) enabled cycles.
`timescale 1ns/1ps
module tick_div
   import clk_rst_pkg::*;
#(
   parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic                 load,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] shadow;
   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] term;

   // Divisors 0 and 1 both collapse to a terminal count of 0 (tick every cycle).
   always_comb begin
      term = '0;
      if (shadow != '0) begin
         term = shadow - DIV_WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         shadow <= DIV_WIDTH'(1);
         cnt    <= '0;
         tick   <= 1'b0;
      end else if (load) begin
         shadow <= div;
         cnt    <= '0;
         tick   <= 1'b0;
      end else if (en) begin
         if (cnt == term) begin
            cnt  <= '0;
            tick <= 1'b1;
         end else begin
            cnt  <= cnt + DIV_WIDTH'(1);
            tick <= 1'b0;
         end
      end else begin
         cnt  <= '0;
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/reset_tick_gen.sv
// PLL-lock qualified reset sequencer with NUM_CH programmable tick-enable
// channels that only run while the SoC is out of reset.
`timescale 1ns/1ps
module reset_tick_gen
   import clk_rst_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        pll_locked,
   input  logic [NUM_CH*DIV_WIDTH-1:0] div_i,
   input  logic                        div_load,
   output logic                        sys_reset,
   output logic [NUM_CH-1:0]           tick_o,
   output logic                        run
);

   localparam int FILT_W = counter_width(LOCK_FILTER);
   localparam int HOLD_W = counter_width(HOLD_CYCLES);
   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic              lock_meta;
   logic              lock_s;
   rst_state_t        state;
   logic [FILT_W-1:0] filt_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              ch_en;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
      end
   end

   // sys_reset and run are updated on the same edge as the state they reflect.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= ST_WAIT_LOCK;
         filt_cnt  <= '0;
         hold_cnt  <= '0;
         sys_reset <= 1'b1;
         run       <= 1'b0;
      end else begin
         case (state)
            ST_WAIT_LOCK: begin
               if (!lock_s) begin
                  filt_cnt <= '0;
               end else if (filt_cnt == FILT_LAST) begin
                  filt_cnt <= '0;
                  hold_cnt <= '0;
                  state    <= ST_HOLD;
               end else begin
                  filt_cnt <= filt_cnt + FILT_W'(1);
               end
            end
            ST_HOLD: begin
               if (!lock_s) begin
                  filt_cnt <= '0;
                  hold_cnt <= '0;
                  state    <= ST_WAIT_LOCK;
               end else if (hold_cnt == HOLD_LAST) begin
                  hold_cnt  <= '0;
                  state     <= ST_RUN;
                  sys_reset <= 1'b0;
                  run       <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  filt_cnt  <= '0;
                  state     <= ST_WAIT_LOCK;
                  sys_reset <= 1'b1;
                  run       <= 1'b0;
               end
            end
            default: begin
               filt_cnt  <= '0;
               hold_cnt  <= '0;
               state     <= ST_WAIT_LOCK;
               sys_reset <= 1'b1;
               run       <= 1'b0;
            end
         endcase
      end
   end

   // Gating with lock_s clears the counters on the very edge RUN is left,
   // so no tick can appear in the first cycle of reset.
   assign ch_en = run & lock_s;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      tick_div #(
         .DIV_WIDTH(DIV_WIDTH)
      ) u_div (
         .clock   (clock),
         .reset_n (reset_n),
         .en      (ch_en),
         .load    (div_load),
         .div     (div_i[k*DIV_WIDTH +: DIV_WIDTH]),
         .tick    (tick_o[k])
      );
   end

endmodule

// File: tb/tb_reset_tick_gen.sv
// Scenario bench for reset_tick_gen: lock qualification timing, divisor loads,
// lock loss/relock and mid-run reset, checked against an arithmetic tick model.
`timescale 1ns/1ps
module tb_reset_tick_gen;

   localparam int NUM_CH       = 2;
   localparam int DIV_WIDTH    = 16;
   localparam int HOLD_CYCLES  = 256;
   localparam int LOCK_FILTER  = 16;
   localparam int LOCK_LATENCY = 2 + LOCK_FILTER + HOLD_CYCLES;

   logic                        clock = 1'b0;
   logic                        reset_n;
   logic                        pll_locked;
   logic [NUM_CH*DIV_WIDTH-1:0] div_i;
   logic                        div_load;
   logic                        sys_reset;
   logic [NUM_CH-1:0]           tick_o;
   logic                        run;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int anchor [NUM_CH];
   int per    [NUM_CH];

   always #5 clock = ~clock;

   reset_tick_gen #(
      .NUM_CH      (NUM_CH),
      .DIV_WIDTH   (DIV_WIDTH),
      .HOLD_CYCLES (HOLD_CYCLES),
      .LOCK_FILTER (LOCK_FILTER)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .pll_locked (pll_locked),
      .div_i      (div_i),
      .div_load   (div_load),
      .sys_reset  (sys_reset),
      .tick_o     (tick_o),
      .run        (run)
   );

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick_edge();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   function automatic int period_of(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   // A channel anchored at edge A with period P ticks after every edge A+n*P, n>=1.
   function automatic logic [NUM_CH-1:0] model_ticks();
      logic [NUM_CH-1:0] t;
      t = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (cyc > anchor[k] && ((cyc - anchor[k]) % per[k]) == 0) t[k] = 1'b1;
      end
      return t;
   endfunction

   task automatic load_divs(input logic [NUM_CH*DIV_WIDTH-1:0] v);
      div_i    = v;
      div_load = 1'b1;
      tick_edge();
      div_load = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         anchor[k] = cyc;
         per[k]    = period_of(int'(v[k*DIV_WIDTH +: DIV_WIDTH]));
      end
   endtask

   task automatic wait_for_run(output int n);
      n = -1;
      for (int i = 1; i <= LOCK_LATENCY + 100; i++) begin
         tick_edge();
         if (sys_reset === 1'b0) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic anchor_run_start();
      for (int k = 0; k < NUM_CH; k++) anchor[k] = cyc;
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      pll_locked = 1'b1;
      div_load   = 1'b0;
      div_i      = '0;
      repeat (3) tick_edge();
      for (int k = 0; k < NUM_CH; k++) per[k] = 1;
      total++;
      if (sys_reset !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_sys_reset: got %b want 1", sys_reset);
      end
      total++;
      if (run !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_run: got %b want 0", run);
      end
      total++;
      if (tick_o !== '0) begin
         bad++;
         $display("[TB] FAIL reset_tick: got %b want 0", tick_o);
      end
   endtask

   task automatic test_lock_sequence();
      int n;
      logic [NUM_CH-1:0] exp;
      reset_n = 1'b1;
      wait_for_run(n);
      total++;
      if (n != LOCK_LATENCY) begin
         bad++;
         $display("[TB] FAIL lock_latency: got %0d want %0d", n, LOCK_LATENCY);
      end
      total++;
      if (run !== 1'b1) begin
         bad++;
         $display("[TB] FAIL lock_run: got %b want 1", run);
      end
      anchor_run_start();
      repeat (8) begin
         tick_edge();
         exp = model_ticks();
         total++;
         if (tick_o !== exp) begin
            bad++;
            $display("[TB] FAIL default_ticks cyc %0d: got %b want %b", cyc, tick_o, exp);
         end
      end
   endtask

   task automatic test_div_load();
      logic [NUM_CH-1:0] exp;
      load_divs({16'd0, 16'd4});
      total++;
      if (tick_o !== 2'b00) begin
         bad++;
         $display("[TB] FAIL load_edge_tick: got %b want 00", tick_o);
      end
      repeat (12) begin
         tick_edge();
         exp = model_ticks();
         total++;
         if (tick_o !== exp) begin
            bad++;
            $display("[TB] FAIL div4_div0 cyc %0d: got %b want %b", cyc, tick_o, exp);
         end
      end
   endtask

   task automatic test_load_at_terminal();
      logic [NUM_CH-1:0] exp;
      load_divs({16'd4, 16'd4});
      repeat (3) begin
         tick_edge();
         exp = model_ticks();
         total++;
         if (tick_o !== exp) begin
            bad++;
            $display("[TB] FAIL pre_terminal cyc %0d: got %b want %b", cyc, tick_o, exp);
         end
      end
      load_divs({16'd4, 16'd4});
      total++;
      if (tick_o !== 2'b00) begin
         bad++;
         $display("[TB] FAIL terminal_load_tick: got %b want 00", tick_o);
      end
      repeat (9) begin
         tick_edge();
         exp = model_ticks();
         total++;
         if (tick_o !== exp) begin
            bad++;
            $display("[TB] FAIL post_terminal cyc %0d: got %b want %b", cyc, tick_o, exp);
         end
      end
   endtask

   task automatic test_random_loads();
      int choices [7] = '{0, 1, 2, 3, 5, 7, 65535};
      logic [NUM_CH*DIV_WIDTH-1:0] v;
      logic [NUM_CH-1:0] exp;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
               v[k*DIV_WIDTH +: DIV_WIDTH] = DIV_WIDTH'(choices[$urandom_range(0, 6)]);
            end
            load_divs(v);
         end else begin
            tick_edge();
         end
         exp = model_ticks();
         total++;
         if (tick_o !== exp) begin
            bad++;
            $display("[TB] FAIL random_ticks cyc %0d: got %b want %b", cyc, tick_o, exp);
         end
      end
   endtask

   task automatic test_lock_loss();
      int n;
      logic [NUM_CH-1:0] exp;
      load_divs({16'd2, 16'd3});
      repeat (6) tick_edge();
      pll_locked = 1'b0;
      repeat (3) tick_edge();
      total++;
      if (sys_reset !== 1'b1) begin
         bad++;
         $display("[TB] FAIL loss_sys_reset: got %b want 1", sys_reset);
      end
      total++;
      if (run !== 1'b0) begin
         bad++;
         $display("[TB] FAIL loss_run: got %b want 0", run);
      end
      total++;
      if (tick_o !== '0) begin
         bad++;
         $display("[TB] FAIL loss_tick: got %b want 0", tick_o);
      end
      pll_locked = 1'b1;
      wait_for_run(n);
      total++;
      if (n != LOCK_LATENCY) begin
         bad++;
         $display("[TB] FAIL relock_latency: got %0d want %0d", n, LOCK_LATENCY);
      end
      anchor_run_start();
      repeat (12) begin
         tick_edge();
         exp = model_ticks();
         total++;
         if (tick_o !== exp) begin
            bad++;
            $display("[TB] FAIL retained_divs cyc %0d: got %b want %b", cyc, tick_o, exp);
         end
      end
   endtask

   task automatic test_glitchy_lock();
      int n;
      int leaks;
      leaks = 0;
      pll_locked = 1'b0;
      repeat (4) tick_edge();
      for (int i = 0; i < 600; i++) begin
         pll_locked = (i % 10 != 9);
         tick_edge();
         if (sys_reset !== 1'b1 || tick_o !== '0) leaks++;
      end
      total++;
      if (leaks != 0) begin
         bad++;
         $display("[TB] FAIL glitch_hold: got %0d cycles out of reset want 0", leaks);
      end
      pll_locked = 1'b1;
      wait_for_run(n);
      total++;
      if (n != LOCK_LATENCY) begin
         bad++;
         $display("[TB] FAIL glitch_relock_latency: got %0d want %0d", n, LOCK_LATENCY);
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      logic [NUM_CH-1:0] exp;
      load_divs({16'd4, 16'd4});
      repeat (5) tick_edge();
      reset_n  = 1'b0;
      div_load = 1'b1;
      div_i    = {16'd7, 16'd7};
      tick_edge();
      reset_n  = 1'b1;
      div_load = 1'b0;
      for (int k = 0; k < NUM_CH; k++) per[k] = 1;
      total++;
      if (sys_reset !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midrst_sys_reset: got %b want 1", sys_reset);
      end
      total++;
      if (run !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midrst_run: got %b want 0", run);
      end
      total++;
      if (tick_o !== '0) begin
         bad++;
         $display("[TB] FAIL midrst_tick: got %b want 0", tick_o);
      end
      wait_for_run(n);
      total++;
      if (n != LOCK_LATENCY) begin
         bad++;
         $display("[TB] FAIL midrst_latency: got %0d want %0d", n, LOCK_LATENCY);
      end
      anchor_run_start();
      repeat (6) begin
         tick_edge();
         exp = model_ticks();
         total++;
         if (tick_o !== exp) begin
            bad++;
            $display("[TB] FAIL midrst_divs cyc %0d: got %b want %b", cyc, tick_o, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock_sequence();
      test_div_load();
      test_load_at_terminal();
      test_random_loads();
      test_lock_loss();
      test_glitchy_lock();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
